ldtu_hamm_odecoder: RTL and testbench

Read-side Hamming decoder stage of the LiTe-DTU output path. It sits directly downstream of the 16-deep Hamming storage FIFO and pulls 38-bit protected words from it with `read_signal`. Each word is captured on the FIFO's `decode_signal`, single-bit errors are corrected, and uncorrectable words are flagged. The recovered 32-bit words go through a 2-entry valid/ready output buffer to the serializer.

---
 rtl/ldtu_hamm_odecoder.sv | 132 +++++++++++++
 tb/tb_ldtu_hamm_odecoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_hamm_odecoder.sv
// Read-side Hamming decoder for the LiTe-DTU output path: pulls 38-bit words from the
// Hamming FIFO, corrects single-bit errors, flags uncorrectable words, buffers two results.
module ldtu_hamm_odecoder #(
  parameter int Nbits_ham  = 38,
  parameter int Nbits_data = 32,
  parameter int Nbits_cnt  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  empty_signal,
  input  logic [Nbits_ham-1:0]  data_input,
  input  logic                  decode_signal,
  output logic                  read_signal,
  output logic [Nbits_data-1:0] data_out,
  output logic                  data_ded,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  sec_error,
  output logic                  ded_error,
  output logic [Nbits_cnt-1:0]  sec_count,
  output logic [Nbits_cnt-1:0]  ded_count,
  input  logic                  clear_counters
);

  localparam int Nsyn = 6;

  logic [Nsyn-1:0]       syn;
  logic [Nbits_ham-1:0]  fixed;
  logic [Nbits_data-1:0] dec_data;
  logic                  dec_sec;
  logic                  dec_ded;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    syn = '0;
    for (int p = 1; p <= Nbits_ham; p++) begin
      for (int k = 0; k < Nsyn; k++) begin
        if (((p >> k) & 1) == 1) syn[k] = syn[k] ^ data_input[p-1];
      end
    end

    // Syndromes above the word length match no position, so DED words pass through unmodified.
    fixed = data_input;
    for (int p = 1; p <= Nbits_ham; p++) begin
      if (syn == Nsyn'(p)) fixed[p-1] = ~data_input[p-1];
    end

    // Data bit index = position - 1 - (number of parity positions at or below it).
    dec_data = '0;
    for (int p = 1; p <= Nbits_ham; p++) begin
      if ((p & (p - 1)) != 0) dec_data[p - 1 - $clog2(p + 1)] = fixed[p-1];
    end

    dec_sec = (syn != '0) && (syn <= Nsyn'(Nbits_ham));
    dec_ded = (syn > Nsyn'(Nbits_ham));
  end

  logic [Nbits_data-1:0] slot0_data;
  logic [Nbits_data-1:0] slot1_data;
  logic                  slot0_ded;
  logic                  slot1_ded;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit;

  assign push       = decode_signal;
  assign data_valid = (occ != 2'd0);
  assign pop        = data_valid && data_ready;
  assign data_out   = slot0_data;
  assign data_ded   = slot0_ded;

  // A read is issued only when the word it returns is sure to find a free slot.
  assign credit      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign read_signal = !reset && !empty_signal && (credit < 3'd2);

  // NOTE: the two buffer slots are reset like any register because data_out must read 0 out of reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slot0_data <= '0;
      slot1_data <= '0;
      slot0_ded  <= 1'b0;
      slot1_ded  <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      sec_error  <= 1'b0;
      ded_error  <= 1'b0;
      sec_count  <= '0;
      ded_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
      inflight  <= read_signal;
      sec_error <= push && dec_sec;
      ded_error <= push && dec_ded;

      if (push && !pop) begin
        if (occ == 2'd0) begin
          slot0_data <= dec_data;
          slot0_ded  <= dec_ded;
        end else begin
          slot1_data <= dec_data;
          slot1_ded  <= dec_ded;
        end
        occ <= occ + 2'd1;
      end else if (!push && pop) begin
        slot0_data <= slot1_data;
        slot0_ded  <= slot1_ded;
        occ        <= occ - 2'd1;
      end else if (push && pop) begin
        if (occ == 2'd1) begin
          slot0_data <= dec_data;
          slot0_ded  <= dec_ded;
        end else begin
          slot0_data <= slot1_data;
          slot0_ded  <= slot1_ded;
          slot1_data <= dec_data;
          slot1_ded  <= dec_ded;
        end
      end

      if (clear_counters) begin
        sec_count <= '0;
        ded_count <= '0;
      end else begin
        if (push && dec_sec && (sec_count != '1)) sec_count <= sec_count + 1'b1;
        if (push && dec_ded && (ded_count != '1)) ded_count <= ded_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_hamm_odecoder.sv
// Bench for ldtu_hamm_odecoder: a queue-based FIFO model feeds encoded/corrupted words and a
// scoreboard checks decoded data, error pulses, counters and the read credit rule every cycle.
module tb_ldtu_hamm_odecoder;

  logic        CLK = 1'b0;
  logic        reset;
  logic        empty_signal;
  logic [37:0] data_input;
  logic        decode_signal;
  logic        read_signal;
  logic [31:0] data_out;
  logic        data_ded;
  logic        data_valid;
  logic        data_ready;
  logic        sec_error;
  logic        ded_error;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic        clear_counters;

  ldtu_hamm_odecoder dut (
    .CLK            (CLK),
    .reset          (reset),
    .empty_signal   (empty_signal),
    .data_input     (data_input),
    .decode_signal  (decode_signal),
    .read_signal    (read_signal),
    .data_out       (data_out),
    .data_ded       (data_ded),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .sec_error      (sec_error),
    .ded_error      (ded_error),
    .sec_count      (sec_count),
    .ded_count      (ded_count),
    .clear_counters (clear_counters)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [37:0] w;
    logic [31:0] d;
    logic        ded;
    logic        sec;
  } item_t;

  item_t q[$];
  item_t ex[$];
  item_t cur;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_rd = 0, n_pop = 0, n_secp = 0, n_dedp = 0;
  int last_rd_cyc = 0, last_pop_cyc = 0;
  int m_sec = 0, m_ded = 0;
  logic last_sec = 1'b0, last_ded = 1'b0, prev_rd = 1'b0;
  logic prev_hold = 1'b0, prev_ded_out = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Encoder: data bits go to the non-power-of-two positions; parity bits cancel the syndrome.
  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [37:0] w;
    logic [5:0]  s;
    int          j;
    w = '0; s = '0; j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin w[p-1] = d[j]; j++; end
    for (int p = 1; p <= 38; p++)
      if (w[p-1]) s = s ^ 6'(p);
    for (int k = 0; k < 6; k++)
      if (s[k]) w[(1 << k) - 1] = 1'b1;
    return w;
  endfunction

  function automatic item_t mk_enc(input logic [31:0] d, input int flip_pos);
    item_t it;
    it.w = enc(d);
    if (flip_pos > 0) it.w[flip_pos-1] = ~it.w[flip_pos-1];
    it.d   = d;
    it.sec = (flip_pos > 0);
    it.ded = 1'b0;
    return it;
  endfunction

  function automatic item_t mk_raw(input logic [37:0] w);
    item_t       it;
    logic [5:0]  s;
    logic [37:0] f;
    int          j;
    s = '0;
    for (int p = 1; p <= 38; p++)
      if (w[p-1]) s = s ^ 6'(p);
    f = w;
    if (s >= 1 && s <= 38) f[s-1] = ~f[s-1];
    it.d = '0; j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin it.d[j] = f[p-1]; j++; end
    it.w   = w;
    it.sec = (s >= 1 && s <= 38);
    it.ded = (s > 38);
    return it;
  endfunction

  function automatic item_t mk_rand();
    logic [37:0] r;
    case ($urandom_range(0, 2))
      0:       return mk_enc($urandom, 0);
      1:       return mk_enc($urandom, int'($urandom_range(1, 38)));
      default: begin
        r = {6'($urandom_range(0, 63)), 32'($urandom)};
        return mk_raw(r);
      end
    endcase
  endfunction

  task automatic fifo_push(input item_t it);
    q.push_back(it);
    empty_signal = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, update the model at the rising edge,
  // then let the FIFO model answer the read sampled in this cycle.
  task automatic step();
    int   m_occ;
    logic m_pop, exp_rd, rd;
    item_t e;
    @(negedge CLK);
    cyc++;
    m_occ = ex.size() - (decode_signal ? 1 : 0);
    m_pop = (m_occ != 0) && data_ready;
    exp_rd = (q.size() != 0) && ((m_occ + int'(prev_rd) - int'(m_pop)) < 2);
    check("data_valid", data_valid, m_occ != 0);
    check("read_signal", read_signal, exp_rd);
    check("sec_error", sec_error, last_sec);
    check("ded_error", ded_error, last_ded);
    check("sec_count", sec_count, m_sec);
    check("ded_count", ded_count, m_ded);
    if (prev_hold && data_valid) begin
      check("hold_data", data_out, prev_data);
      check("hold_ded", data_ded, prev_ded_out);
    end
    if (data_valid && data_ready) begin
      if (ex.size() == 0) check("unexpected_word", ex.size(), 1);
      else begin
        e = ex.pop_front();
        check("data_out", data_out, e.d);
        check("data_ded", data_ded, e.ded);
        n_pop++;
        last_pop_cyc = cyc;
      end
    end
    n_secp += int'(sec_error);
    n_dedp += int'(ded_error);
    rd = read_signal;
    if (rd) begin n_rd++; last_rd_cyc = cyc; end
    prev_hold    = data_valid && !data_ready;
    prev_data    = data_out;
    prev_ded_out = data_ded;

    @(posedge CLK);
    if (clear_counters) begin
      m_sec = 0; m_ded = 0;
    end else begin
      if (decode_signal && cur.sec && m_sec != 16'hFFFF) m_sec++;
      if (decode_signal && cur.ded && m_ded != 16'hFFFF) m_ded++;
    end
    last_sec = decode_signal && cur.sec;
    last_ded = decode_signal && cur.ded;
    prev_rd  = rd;
    #1;
    if (rd && q.size() != 0) begin
      cur = q.pop_front();
      data_input    = cur.w;
      decode_signal = 1'b1;
      ex.push_back(cur);
    end else begin
      decode_signal = 1'b0;
      data_input    = {6'($urandom_range(0, 63)), 32'($urandom)};
    end
    empty_signal = (q.size() == 0);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || ex.size() != 0 || data_valid); i++) step();
    check("drain_done", q.size() + ex.size(), 0);
  endtask

  int r0, p0, s0, d0, rem, fed;

  initial begin
    reset = 1'b1; empty_signal = 1'b1; decode_signal = 1'b0; data_input = '0;
    data_ready = 1'b1; clear_counters = 1'b0; cur = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_read", read_signal, 0);
    check("rst_sec_cnt", sec_count, 0);
    reset = 1'b0;

    // Clean word
    fifo_push(mk_enc(32'hA5A5_5A5A, 0));
    r0 = n_rd; p0 = n_pop; s0 = n_secp; d0 = n_dedp;
    repeat (6) step();
    check("clean_rd_pulses", n_rd - r0, 1);
    check("clean_latency", last_pop_cyc - last_rd_cyc, 2);
    check("clean_delivered", n_pop - p0, 1);
    check("clean_no_pulse", (n_secp - s0) + (n_dedp - d0), 0);

    // Single-bit error at position 3
    fifo_push(mk_enc(32'h0000_0001, 3));
    p0 = n_pop; s0 = n_secp;
    repeat (6) step();
    check("sec_delivered", n_pop - p0, 1);
    check("sec_pulses", n_secp - s0, 1);
    check("sec_count_1", sec_count, 16'd1);

    // Uncorrectable word
    fifo_push(mk_raw(38'h3F_FFFF_FFFF));
    p0 = n_pop; d0 = n_dedp;
    repeat (6) step();
    check("ded_delivered", n_pop - p0, 1);
    check("ded_pulses", n_dedp - d0, 1);
    check("ded_count_1", ded_count, 16'd1);

    // Backpressure: 8 words, 10-cycle stall
    data_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_push(mk_enc($urandom, int'($urandom_range(0, 38))));
    r0 = n_rd; p0 = n_pop;
    repeat (10) step();
    check("stall_rd_pulses", n_rd - r0, 2);
    drain();
    check("bp_delivered", n_pop - p0, 8);
    check("bp_empty", empty_signal, 1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < 6) fifo_push(mk_rand());
      data_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset while streaming: buffer occupied and a word on the FIFO bus
    data_ready = 1'b1;
    for (int i = 0; i < 6; i++) fifo_push(mk_enc($urandom, int'($urandom_range(1, 38))));
    repeat (4) step();
    #3;
    reset = 1'b1;
    decode_signal = 1'b0;
    #1;
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ded", data_ded, 0);
    check("mid_rst_read", read_signal, 0);
    check("mid_rst_sec_err", sec_error, 0);
    check("mid_rst_ded_err", ded_error, 0);
    check("mid_rst_sec_cnt", sec_count, 0);
    check("mid_rst_ded_cnt", ded_count, 0);
    ex.delete();
    m_sec = 0; m_ded = 0; last_sec = 1'b0; last_ded = 1'b0;
    prev_rd = 1'b0; prev_hold = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    rem = q.size(); p0 = n_pop;
    drain();
    check("post_rst_delivered", n_pop - p0, rem);

    // Saturate sec_count
    fed = 0;
    data_ready = 1'b1;
    while (fed < 65540) begin
      if (q.size() < 4) begin
        fifo_push(mk_enc($urandom, int'($urandom_range(1, 38))));
        fed++;
      end
      step();
    end
    drain();
    check("sec_saturated", sec_count, 16'hFFFF);

    // Clear in the same cycle as a SEC push
    fifo_push(mk_enc($urandom, 7));
    for (int i = 0; i < 10 && !decode_signal; i++) step();
    check("clear_push_seen", decode_signal, 1);
    s0 = n_secp;
    clear_counters = 1'b1;
    step();
    clear_counters = 1'b0;
    step();
    check("clear_wins", sec_count, 16'd0);
    check("clear_sec_pulse", n_secp - s0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
